fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register for the pipelined RV32I core.
- Drives a single-outstanding, variable-latency instruction-memory request/response port and owns PCF.
- Presents InstrD/PCD/PCPlus4D/ValidD to decode.
- Consumes StallFetch, StallDecode and FlushDecode from the hazard unit, and the execute-stage redirect (PCSrcE, PCTargetE).

---
 rtl/fetch_stage.sv | 176 +++++++++++++++++
 tb/tb_fetch_stage.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction-fetch stage and IF/ID pipeline register.
// Latency: request accepted in cycle N, response in N+k -> ValidD in N+k+1.
// Backpressure: one request in flight; StallDecode parks a response in a one-entry skid buffer.
//
// Ports: clk/rst_n (async active-low); hazard inputs StallFetch, StallDecode,
// FlushDecode; execute redirect PCSrcE/PCTargetE; imem request (imem_req,
// imem_addr, imem_ready) and response (imem_rvalid, imem_rdata); decode
// outputs InstrD, PCD, PCPlus4D, ValidD.
// Optional: define FETCH_PERF_EN to add perf_fetched / perf_dropped counters.
module fetch_stage #(
    parameter int                      ADDR_WIDTH  = 32,
    parameter int                      INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]   RESET_PC    = {ADDR_WIDTH{1'b0}},
    parameter logic [INSTR_WIDTH-1:0]  NOP_INSTR   = INSTR_WIDTH'(32'h0000_0013)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   StallFetch,
    input  logic                   StallDecode,
    input  logic                   FlushDecode,
    input  logic                   PCSrcE,
    input  logic [ADDR_WIDTH-1:0]  PCTargetE,
    output logic                   imem_req,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic                   imem_ready,
    input  logic                   imem_rvalid,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [INSTR_WIDTH-1:0] InstrD,
    output logic [ADDR_WIDTH-1:0]  PCD,
    output logic [ADDR_WIDTH-1:0]  PCPlus4D,
    output logic                   ValidD
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]            perf_fetched,
    output logic [31:0]            perf_dropped
`endif
);

    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t                  state, state_n;
    logic [ADDR_WIDTH-1:0]   pcf;
    logic [ADDR_WIDTH-1:0]   fetch_pc;
    logic [INSTR_WIDTH-1:0]  skid_instr;
    logic                    issue;
    logic                    deliver;
    logic                    capture;
    logic                    drop;
    logic [INSTR_WIDTH-1:0]  deliver_instr;

    assign imem_addr = pcf;

    // Only the instruction word needs buffering: fetch_pc cannot change while
    // a response is parked, because a new issue is only possible from IDLE.
    assign deliver_instr = (state == HOLD) ? skid_instr : imem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        deliver  = 1'b0;
        capture  = 1'b0;
        drop     = 1'b0;
        // rst_n gating keeps the request low while reset is asserted.
        imem_req = rst_n && (state == IDLE) && !StallFetch && !PCSrcE;
        issue    = imem_req && imem_ready;
        case (state)
            IDLE: begin
                if (issue) state_n = WAIT;
            end
            WAIT: begin
                if (PCSrcE) begin
                    state_n = imem_rvalid ? IDLE : DROP;
                    drop    = imem_rvalid;
                end else if (imem_rvalid) begin
                    if (StallDecode) begin
                        state_n = HOLD;
                        capture = 1'b1;
                    end else begin
                        state_n = IDLE;
                        deliver = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (PCSrcE) begin
                    state_n = IDLE;
                    drop    = 1'b1;
                end else if (!StallDecode) begin
                    state_n = IDLE;
                    deliver = 1'b1;
                end
            end
            DROP: begin
                // The stale response always retires DROP, even alongside a
                // further redirect; otherwise we would wait for a response
                // that has already gone by.
                if (imem_rvalid) begin
                    state_n = IDLE;
                    drop    = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // PC and skid buffer. Redirect wins; issue never coincides with PCSrcE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcf        <= RESET_PC;
            fetch_pc   <= RESET_PC;
            skid_instr <= NOP_INSTR;
        end else begin
            if (PCSrcE) begin
                pcf <= PCTargetE;
            end else if (issue) begin
                pcf <= pcf + PC_STEP;
            end
            if (issue) fetch_pc <= pcf;
            if (capture) skid_instr <= imem_rdata;
        end
    end

    // IF/ID register: flush, then hold, then load, else bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (FlushDecode) begin
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (StallDecode) begin
            InstrD   <= InstrD;
        end else if (deliver) begin
            InstrD   <= deliver_instr;
            PCD      <= fetch_pc;
            PCPlus4D <= fetch_pc + PC_STEP;
            ValidD   <= 1'b1;
        end else begin
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_dropped <= '0;
        end else begin
            if (deliver && !FlushDecode) perf_fetched <= perf_fetched + 32'd1;
            if (drop) perf_dropped <= perf_dropped + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        StallFetch, StallDecode, FlushDecode, PCSrcE;
    logic [31:0] PCTargetE;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready, imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_dropped;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // memory responder state
    int          mem_lat  = 1;
    int          pend_cnt = 0;
    logic [31:0] pend_data;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n),
        .StallFetch(StallFetch), .StallDecode(StallDecode), .FlushDecode(FlushDecode),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_dropped(perf_dropped)
`endif
    );

    function automatic logic [31:0] tag(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    // One clock: sample handshake before the edge, then update the memory
    // model (fixed latency mem_lat) just after it.
    task automatic tick();
        logic        hs;
        logic [31:0] ha;
        #1;
        hs = imem_req & imem_ready;
        ha = imem_addr;
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        if (!rst_n) pend_cnt = 0;
        if (hs) begin
            pend_cnt  = mem_lat;
            pend_data = tag(ha);
        end
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = pend_data;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        StallFetch = 0; StallDecode = 0; FlushDecode = 0; PCSrcE = 0;
        PCTargetE = 32'h0; imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (ValidD !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b want 0", ValidD); end
        vectors++; if (InstrD !== 32'h13) begin miscompares++; $display("FAIL rst_instr: got %h want 00000013", InstrD); end
        vectors++; if (PCD !== 32'h0) begin miscompares++; $display("FAIL rst_pcd: got %h want 0", PCD); end
        vectors++; if (PCPlus4D !== 32'h0) begin miscompares++; $display("FAIL rst_pcp4: got %h want 0", PCPlus4D); end
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL rst_req: got %b want 0", imem_req); end
    endtask

    task automatic test_sequential();
        logic [31:0] a;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 32'(4 * i);
            #1;
            vectors++; if (imem_req !== 1'b1 || imem_addr !== a) begin miscompares++; $display("FAIL seq_req: got req=%b addr=%h want 1 %h", imem_req, imem_addr, a); end
            tick();
            vectors++; if (ValidD !== 1'b0) begin miscompares++; $display("FAIL seq_gap: got %b want 0", ValidD); end
            tick();
            vectors++; if (ValidD !== 1'b1 || PCD !== a) begin miscompares++; $display("FAIL seq_pcd: got v=%b pcd=%h want 1 %h", ValidD, PCD, a); end
            vectors++; if (InstrD !== tag(a)) begin miscompares++; $display("FAIL seq_instr: got %h want %h", InstrD, tag(a)); end
            vectors++; if (PCPlus4D !== a + 32'd4) begin miscompares++; $display("FAIL seq_pcp4: got %h want %h", PCPlus4D, a + 32'd4); end
        end
    endtask

    task automatic test_redirect();
        // request 0xC in flight with 3-cycle latency, redirect during WAIT
        mem_lat = 3;
        tick();
        PCSrcE = 1'b1; PCTargetE = 32'h100; #1;
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL redir_req: got %b want 0", imem_req); end
        tick();
        PCSrcE = 1'b0;
        vectors++; if (ValidD !== 1'b0) begin miscompares++; $display("FAIL redir_v1: got %b want 0", ValidD); end
        tick();
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL drop_req: got %b want 0", imem_req); end
        tick();
        vectors++; if (ValidD !== 1'b0) begin miscompares++; $display("FAIL drop_valid: got %b want 0", ValidD); end
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin miscompares++; $display("FAIL redir_addr: got req=%b addr=%h want 1 00000100", imem_req, imem_addr); end
        mem_lat = 1;
        tick(); tick();
        vectors++; if (ValidD !== 1'b1 || PCD !== 32'h100 || InstrD !== tag(32'h100)) begin miscompares++; $display("FAIL redir_pcd: got v=%b pcd=%h instr=%h want 1 00000100 %h", ValidD, PCD, InstrD, tag(32'h100)); end
`ifdef FETCH_PERF_EN
        vectors++; if (perf_dropped !== 32'd1) begin miscompares++; $display("FAIL perf_drop1: got %0d want 1", perf_dropped); end
`endif
        // redirect in the same cycle the response arrives
        tick();
        PCSrcE = 1'b1; PCTargetE = 32'h200; #1;
        vectors++; if (imem_req !== 1'b0 || imem_rvalid !== 1'b1) begin miscompares++; $display("FAIL redir_rv: got req=%b rvalid=%b want 0 1", imem_req, imem_rvalid); end
        tick();
        PCSrcE = 1'b0; #1;
        vectors++; if (ValidD !== 1'b0) begin miscompares++; $display("FAIL redir_rv_valid: got %b want 0", ValidD); end
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin miscompares++; $display("FAIL redir_rv_addr: got req=%b addr=%h want 1 00000200", imem_req, imem_addr); end
`ifdef FETCH_PERF_EN
        vectors++; if (perf_dropped !== 32'd2) begin miscompares++; $display("FAIL perf_drop2: got %0d want 2", perf_dropped); end
`endif
        tick(); tick();
        vectors++; if (ValidD !== 1'b1 || PCD !== 32'h200) begin miscompares++; $display("FAIL redir2_pcd: got v=%b pcd=%h want 1 00000200", ValidD, PCD); end
    endtask

    task automatic test_stall_decode();
        StallDecode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if (ValidD !== 1'b1 || PCD !== 32'h200 || InstrD !== tag(32'h200)) begin miscompares++; $display("FAIL stall_hold%0d: got v=%b pcd=%h want 1 00000200", i, ValidD, PCD); end
            vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL stall_req%0d: got %b want 0", i, imem_req); end
        end
        StallDecode = 1'b0;
        tick();
        vectors++; if (ValidD !== 1'b1 || PCD !== 32'h204 || InstrD !== tag(32'h204)) begin miscompares++; $display("FAIL stall_release: got v=%b pcd=%h instr=%h want 1 00000204 %h", ValidD, PCD, InstrD, tag(32'h204)); end
    endtask

    task automatic test_flush();
        StallDecode = 1'b1; FlushDecode = 1'b1;
        tick();
        vectors++; if (InstrD !== 32'h13 || ValidD !== 1'b0) begin miscompares++; $display("FAIL flush_bubble: got instr=%h v=%b want 00000013 0", InstrD, ValidD); end
        vectors++; if (PCD !== 32'h0 || PCPlus4D !== 32'h0) begin miscompares++; $display("FAIL flush_pc: got pcd=%h pcp4=%h want 0 0", PCD, PCPlus4D); end
        StallDecode = 1'b0; FlushDecode = 1'b0;
        tick();
        vectors++; if (ValidD !== 1'b1 || PCD !== 32'h208) begin miscompares++; $display("FAIL flush_next: got v=%b pcd=%h want 1 00000208", ValidD, PCD); end
    endtask

    task automatic test_stall_fetch();
        StallFetch = 1'b1; #1;
        vectors++; if (imem_req !== 1'b0 || imem_addr !== 32'h20C) begin miscompares++; $display("FAIL sf_req: got req=%b addr=%h want 0 0000020c", imem_req, imem_addr); end
        tick(); tick();
        vectors++; if (imem_req !== 1'b0 || imem_addr !== 32'h20C || ValidD !== 1'b0) begin miscompares++; $display("FAIL sf_held: got req=%b addr=%h v=%b want 0 0000020c 0", imem_req, imem_addr, ValidD); end
        StallFetch = 1'b0; #1;
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h20C) begin miscompares++; $display("FAIL sf_release: got req=%b addr=%h want 1 0000020c", imem_req, imem_addr); end
        tick(); tick();
        vectors++; if (ValidD !== 1'b1 || PCD !== 32'h20C) begin miscompares++; $display("FAIL sf_pcd: got v=%b pcd=%h want 1 0000020c", ValidD, PCD); end
`ifdef FETCH_PERF_EN
        vectors++; if (perf_fetched !== 32'd8) begin miscompares++; $display("FAIL perf_fetched: got %0d want 8", perf_fetched); end
`endif
    endtask

    task automatic test_wrap_and_reset();
        PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC; #1;
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL wrap_redir_req: got %b want 0", imem_req); end
        tick();
        PCSrcE = 1'b0; #1;
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_addr: got req=%b addr=%h want 1 fffffffc", imem_req, imem_addr); end
        tick(); tick();
        vectors++; if (ValidD !== 1'b1 || PCD !== 32'hFFFF_FFFC || PCPlus4D !== 32'h0) begin miscompares++; $display("FAIL wrap_pcp4: got v=%b pcd=%h pcp4=%h want 1 fffffffc 0", ValidD, PCD, PCPlus4D); end
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin miscompares++; $display("FAIL wrap_next: got req=%b addr=%h want 1 0", imem_req, imem_addr); end
        // fetch of 0x0 in flight (PCF now 4), then reset mid-WAIT
        mem_lat = 3;
        tick();
        rst_n = 1'b0; pend_cnt = 0; #1;
        vectors++; if (ValidD !== 1'b0 || InstrD !== 32'h13 || imem_req !== 1'b0 || imem_addr !== 32'h0) begin miscompares++; $display("FAIL midreset: got v=%b instr=%h req=%b addr=%h want 0 00000013 0 0", ValidD, InstrD, imem_req, imem_addr); end
`ifdef FETCH_PERF_EN
        vectors++; if (perf_fetched !== 32'd0 || perf_dropped !== 32'd0) begin miscompares++; $display("FAIL perf_reset: got %0d %0d want 0 0", perf_fetched, perf_dropped); end
`endif
        tick();
        rst_n = 1'b1; mem_lat = 1; #1;
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin miscompares++; $display("FAIL postreset_req: got req=%b addr=%h want 1 0", imem_req, imem_addr); end
        tick(); tick();
        vectors++; if (ValidD !== 1'b1 || PCD !== 32'h0 || InstrD !== tag(32'h0)) begin miscompares++; $display("FAIL postreset_pcd: got v=%b pcd=%h instr=%h want 1 0 %h", ValidD, PCD, InstrD, tag(32'h0)); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_redirect();
        test_stall_decode();
        test_flush();
        test_stall_fetch();
        test_wrap_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
